// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor_if: enable, divided clock under test and monitor results
interface clk_div_monitor_if #(
    parameter int CNT_W = 4
);
    logic             en;
    logic             clk_in;
    logic [CNT_W-1:0] half_period;
    logic             meas_valid;
    logic             locked;
    logic             err;
    logic             stall;
    logic [7:0]       err_count;

    modport master (
        output en, clk_in,
        input  half_period, meas_valid, locked, err, stall, err_count
    );

    modport slave (
        input  en, clk_in,
        output half_period, meas_valid, locked, err, stall, err_count
    );
endinterface

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures toggle intervals of a clk-synchronous divided clock
// against DIV+-TOL, tracking lock, mismatch errors and stalls
module clk_div_monitor #(
    parameter int DIV    = 2,
    parameter int TOL    = 0,
    parameter int LOCK_N = 3,
    parameter int CNT_W  = $clog2(2*DIV+TOL+2)+1
) (
    input logic             clk,
    input logic             reset,
    clk_div_monitor_if.slave m
);
    localparam logic [1:0] IDLE = 2'd0, ACQ = 2'd1, LOCK = 2'd2;
    localparam int GW = $clog2(LOCK_N+1);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W:0] LO = (CNT_W+1)'(DIV);
    localparam logic [CNT_W:0] HI = (CNT_W+1)'(DIV+TOL);
    localparam logic [CNT_W:0] TW = (CNT_W+1)'(TOL);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [GW-1:0]    good;
    logic             clk_in_q, tog, active, meas, ok, stall_hit, err_set;

    // TOL is added to cnt rather than subtracted from DIV so TOL>=DIV cannot underflow
    always_comb begin
        tog       = m.clk_in != clk_in_q;
        active    = state != IDLE;
        meas      = active && tog;
        ok        = ({1'b0, cnt} + TW >= LO) && ({1'b0, cnt} <= HI) && !m.stall;
        stall_hit = active && !tog && cnt == MAX - CNT_W'(1);
        err_set   = (meas && !ok && !m.stall) || stall_hit;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= CNT_W'(1);
            clk_in_q      <= m.clk_in;
            good          <= '0;
            m.half_period <= '0;
            m.meas_valid  <= 1'b0;
            m.locked      <= 1'b0;
            m.err         <= 1'b0;
            m.stall       <= 1'b0;
            m.err_count   <= '0;
        end else begin
            clk_in_q     <= m.clk_in;
            m.meas_valid <= m.en && meas;
            m.err        <= m.en && err_set;
            if (m.en && err_set && m.err_count != 8'hff)
                m.err_count <= m.err_count + 8'd1;
            if (!m.en) begin
                state    <= IDLE;
                cnt      <= CNT_W'(1);
                good     <= '0;
                m.locked <= 1'b0;
                m.stall  <= 1'b0;
            end else begin
                cnt     <= tog ? CNT_W'(1) : (cnt == MAX ? cnt : cnt + CNT_W'(1));
                m.stall <= stall_hit || (m.stall && !tog);
                if (meas)
                    m.half_period <= cnt;
                if (!active) begin
                    state <= tog ? ACQ : IDLE;
                end else if (stall_hit || (meas && !ok)) begin
                    state    <= ACQ;
                    good     <= '0;
                    m.locked <= 1'b0;
                end else if (meas && state == ACQ) begin
                    good <= good + GW'(1);
                    if (good == GW'(LOCK_N-1)) begin
                        state    <= LOCK;
                        m.locked <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed checks of clk_div_monitor, DIV=4 with TOL=0 (a) and TOL=1 (b)
module tb_clk_div_monitor;
    logic clk = 1'b0;
    logic reset, en, ck;
    int   vecs = 0, errs = 0;

    always #5 clk = ~clk;

    clk_div_monitor_if #(.CNT_W(5)) ia ();
    clk_div_monitor_if #(.CNT_W(5)) ib ();

    assign ia.en = en;
    assign ia.clk_in = ck;
    assign ib.en = en;
    assign ib.clk_in = ck;

    clk_div_monitor #(.DIV(4), .TOL(0), .LOCK_N(3), .CNT_W(5)) dut_a (.clk(clk), .reset(reset), .m(ia.slave));
    clk_div_monitor #(.DIV(4), .TOL(1), .LOCK_N(3), .CNT_W(5)) dut_b (.clk(clk), .reset(reset), .m(ib.slave));

    task automatic chk(input string tag, input int got, input int exp);
        vecs++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // called one negedge after the previous toggle; toggles so the interval is d
    task automatic iv(input int d);
        repeat (d-1) @(negedge clk);
        ck = ~ck;
        @(negedge clk);
    endtask

    initial begin
        ck = 1'b0;
        en = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hp", ia.half_period, 0);
        chk("rst_mv", ia.meas_valid, 0);
        chk("rst_lock", ia.locked, 0);
        chk("rst_err", ia.err, 0);
        chk("rst_stall", ia.stall, 0);
        chk("rst_ec", ia.err_count, 0);
        reset = 1'b1;

        iv(4);
        chk("t1_arm_mv", ia.meas_valid, 0);
        iv(4);
        chk("t1_mv", ia.meas_valid, 1);
        chk("t1_hp", ia.half_period, 4);
        chk("t1_lock0", ia.locked, 0);
        iv(4);
        chk("t1_lock1", ia.locked, 0);
        iv(4);
        chk("t1_locked", ia.locked, 1);
        chk("t1_noerr", ia.err, 0);

        iv(6);
        chk("t2_err", ia.err, 1);
        chk("t2_hp", ia.half_period, 6);
        chk("t2_unlock", ia.locked, 0);
        chk("t2_ec", ia.err_count, 1);
        @(negedge clk);
        chk("t2_err_pulse", ia.err, 0);
        chk("t2_mv_pulse", ia.meas_valid, 0);
        iv(3);
        chk("t2_relock0", ia.locked, 0);
        iv(4);
        chk("t2_relock1", ia.locked, 0);
        iv(4);
        chk("t2_relocked", ia.locked, 1);
        chk("t2_ec_hold", ia.err_count, 1);

        repeat (29) @(negedge clk);
        chk("t4_pre_stall", ia.stall, 0);
        chk("t4_pre_lock", ia.locked, 1);
        @(negedge clk);
        chk("t4_stall", ia.stall, 1);
        chk("t4_err", ia.err, 1);
        chk("t4_unlock", ia.locked, 0);
        chk("t4_ec", ia.err_count, 2);
        @(negedge clk);
        chk("t4_err_once", ia.err, 0);
        chk("t4_stall_hold", ia.stall, 1);
        iv(5);
        chk("t4_stall_clr", ia.stall, 0);
        chk("t4_mv", ia.meas_valid, 1);
        chk("t4_hp_sat", ia.half_period, 31);
        chk("t4_no_err2", ia.err, 0);
        chk("t4_ec_hold", ia.err_count, 2);
        iv(4);
        iv(4);
        chk("t4_relock0", ia.locked, 0);
        iv(4);
        chk("t4_relocked", ia.locked, 1);

        ck = ~ck;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_hp", ia.half_period, 0);
        chk("t5_mv", ia.meas_valid, 0);
        chk("t5_lock", ia.locked, 0);
        chk("t5_err", ia.err, 0);
        chk("t5_stall", ia.stall, 0);
        chk("t5_ec", ia.err_count, 0);
        reset = 1'b1;
        iv(4);
        chk("t5_arm_mv", ia.meas_valid, 0);
        chk("t5_arm_mv_b", ib.meas_valid, 0);
        iv(4);
        chk("t5_mv", ia.meas_valid, 1);
        chk("t5_hp4", ia.half_period, 4);

        iv(3);
        chk("t3_hp3", ib.half_period, 3);
        chk("t3_err3", ib.err, 0);
        chk("t3_a_err3", ia.err, 1);
        iv(5);
        chk("t3_err5", ib.err, 0);
        chk("t3_lock", ib.locked, 1);
        iv(6);
        chk("t3_err6", ib.err, 1);
        chk("t3_hp6", ib.half_period, 6);
        chk("t3_unlock", ib.locked, 0);
        chk("t3_ec", ib.err_count, 1);
        iv(4);
        iv(4);
        chk("t3_good_reset", ib.locked, 0);
        iv(4);
        chk("t3_relock", ib.locked, 1);
        chk("t3_a_ec", ia.err_count, 3);
        chk("t3_a_lock", ia.locked, 1);

        repeat (251) iv(2);
        chk("t6_ec254", ia.err_count, 254);
        repeat (9) iv(2);
        chk("t6_ec255", ia.err_count, 255);
        chk("t6_err", ia.err, 1);
        en = 1'b0;
        @(negedge clk);
        chk("t6_dis_lock", ia.locked, 0);
        chk("t6_dis_stall", ia.stall, 0);
        iv(4);
        chk("t6_dis_mv", ia.meas_valid, 0);
        chk("t6_dis_err", ia.err, 0);
        chk("t6_dis_hp", ia.half_period, 2);
        chk("t6_dis_ec", ia.err_count, 255);
        en = 1'b1;
        iv(4);
        chk("t6_arm_mv", ia.meas_valid, 0);
        iv(4);
        chk("t6_mv", ia.meas_valid, 1);
        chk("t6_hp", ia.half_period, 4);
        chk("t6_ec_hold", ia.err_count, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
